// File: rtl/tone_gen_8b_pkg.sv
// Shared constants for the square-wave tone generator.
package tone_gen_8b_pkg;
  localparam int NOTE_W = 8;
  localparam logic [NOTE_W-1:0] NOTE_REST = 8'h00;
  localparam int PRESCALE_DEFAULT = 250;
endpackage

// File: rtl/tone_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick marks the last count while running.
module tone_prescaler #(
  parameter int PRESCALE = 250,
  parameter int PS_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst)          cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (run)      cnt <= (cnt == LAST) ? '0 : cnt + PS_W'(1);
  end
endmodule

// File: rtl/tone_gen_8b.sv
// Square-wave tone generator: half-period is note*PRESCALE cycles, with a
// one-cycle strobe on the falling edge that closes each full period.
module tone_gen_8b
  import tone_gen_8b_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PS_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NOTE_W-1:0] note,
  output logic              spk,
  output logic              active,
  output logic              cycle_done
);
  logic [NOTE_W-1:0] note_q;
  logic [NOTE_W-1:0] half_cnt;
  logic change, silent, run, tick;

  assign change = (note != note_q);
  assign silent = !en || (note_q == NOTE_REST);
  assign run    = !change && !silent;

  tone_prescaler #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (!run),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      note_q     <= NOTE_REST;
      half_cnt   <= '0;
      spk        <= 1'b0;
      active     <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      note_q <= note;
      if (change) begin
        // Restart at phase 0; a truncated period never reports completion.
        half_cnt   <= '0;
        spk        <= 1'b0;
        active     <= !silent;
        cycle_done <= 1'b0;
      end else if (silent) begin
        half_cnt   <= '0;
        spk        <= 1'b0;
        active     <= 1'b0;
        cycle_done <= 1'b0;
      end else begin
        active     <= 1'b1;
        cycle_done <= 1'b0;
        if (tick) begin
          if (half_cnt == note_q - NOTE_W'(1)) begin
            half_cnt   <= '0;
            spk        <= ~spk;
            cycle_done <= spk;
          end else begin
            half_cnt <= half_cnt + NOTE_W'(1);
          end
        end
      end
    end
  end
endmodule
